// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types and filter codes for the colour sensor scanner
package color_pkg;

   localparam logic [1:0] CS_RED   = 2'b00;
   localparam logic [1:0] CS_BLUE  = 2'b01;
   localparam logic [1:0] CS_CLEAR = 2'b10;
   localparam logic [1:0] CS_GREEN = 2'b11;

   typedef enum logic [1:0] {RED, GREEN, BLUE, CLEAR} channel_t;

   typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

   function automatic logic [1:0] cs_code(input channel_t ch);
      logic [1:0] code;
      case (ch)
         RED:     code = CS_RED;
         GREEN:   code = CS_GREEN;
         BLUE:    code = CS_BLUE;
         CLEAR:   code = CS_CLEAR;
         default: code = CS_RED;
      endcase
      return code;
   endfunction

   // Scan order is red -> green -> blue -> clear; clear wraps back to red.
   function automatic channel_t next_channel(input channel_t ch);
      channel_t nxt;
      case (ch)
         RED:     nxt = GREEN;
         GREEN:   nxt = BLUE;
         BLUE:    nxt = CLEAR;
         default: nxt = RED;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/color_scan_edge_sync.sv
// rtl/color_scan_edge_sync.sv - two-flop synchroniser with rising-edge detect
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic rise_pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= d_async;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise_pulse = sync & ~sync_d;

endmodule

// File: rtl/color_scan.sv
// rtl/color_scan.sv - TCS3200 filter sequencer and per-channel frequency meter
module color_scan
   import color_pkg::*;
#(
   parameter int GATE_CYCLES   = 1000000,
   parameter int SETTLE_CYCLES = 10000,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             FREQ,
   input  logic             enable,
   output logic [1:0]       CS,
   output logic [CNT_W-1:0] red,
   output logic [CNT_W-1:0] green,
   output logic [CNT_W-1:0] blue,
   output logic [CNT_W-1:0] clear,
   output logic             valid,
   output logic             busy
);

   localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state;
   state_t           state_nxt;
   channel_t         channel;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] shadow_red;
   logic [CNT_W-1:0] shadow_green;
   logic [CNT_W-1:0] shadow_blue;
   logic             rise;

   edge_sync u_freq_sync (
      .clk        (clk),
      .reset      (reset),
      .d_async    (FREQ),
      .rise_pulse (rise)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A clear-STORE always completes its publish, so STORE ignores enable except to pick the successor.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (enable) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!enable)                 state_nxt = IDLE;
            else if (timer == SETTLE_LAST) state_nxt = GATE;
         end
         GATE: begin
            if (!enable)               state_nxt = IDLE;
            else if (timer == GATE_LAST) state_nxt = STORE;
         end
         STORE: begin
            state_nxt = enable ? SETTLE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      CS   = (state == IDLE) ? CS_RED : cs_code(channel);
   end

   // Channel only moves on SETTLE entry so the filter lines change exactly once per window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         channel <= RED;
      end else if (state_nxt == SETTLE && state != SETTLE) begin
         if (state == STORE && channel != CLEAR) channel <= next_channel(channel);
         else                                    channel <= RED;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (state_nxt != state) begin
         timer <= '0;
      end else if (state != IDLE) begin
         timer <= timer + TW'(1);
      end
   end

   // First GATE cycle clears the count, which also discards any edge seen on that cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_cnt <= '0;
      end else if (state == IDLE) begin
         edge_cnt <= '0;
      end else if (state == GATE) begin
         if (timer == '0)                        edge_cnt <= '0;
         else if (rise && edge_cnt != CNT_MAX)   edge_cnt <= edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_red   <= '0;
         shadow_green <= '0;
         shadow_blue  <= '0;
      end else if (state == IDLE) begin
         shadow_red   <= '0;
         shadow_green <= '0;
         shadow_blue  <= '0;
      end else if (state == STORE) begin
         case (channel)
            RED:     shadow_red   <= edge_cnt;
            GREEN:   shadow_green <= edge_cnt;
            BLUE:    shadow_blue  <= edge_cnt;
            default: ;
         endcase
      end
   end

   // Clear's count goes straight to its output alongside the three colour shadows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         clear <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (state == STORE && channel == CLEAR) begin
            red   <= shadow_red;
            green <= shadow_green;
            blue  <= shadow_blue;
            clear <= edge_cnt;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_color_scan.sv
// tb/tb_color_scan.sv - randomized self-checking bench for color_scan
module tb_color_scan;

   localparam int G  = 100;
   localparam int S  = 10;
   localparam int W  = 8;
   localparam int WS = 4;
   localparam int L  = 4 * (S + G + 1);

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic          FREQ   = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    CS, CS_s;
   logic [W-1:0]  red, green, blue, clear;
   logic [WS-1:0] red_s, green_s, blue_s, clear_s;
   logic          valid, busy, valid_s, busy_s;

   logic [W-1:0]  out8 [4];
   logic [WS-1:0] outs [4];
   logic [W-1:0]  exp8 [4];
   logic [WS-1:0] exps [4];
   logic [1:0]    cs_of [4];

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   int     gen_mode = 0;
   int     period [4];
   int     ph = 0;
   longint man_rise [$];
   longint rises [$];

   assign out8[0] = red;   assign out8[1] = green;   assign out8[2] = blue;   assign out8[3] = clear;
   assign outs[0] = red_s; assign outs[1] = green_s; assign outs[2] = blue_s; assign outs[3] = clear_s;

   color_scan #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) dut (
      .clk(clk), .reset(reset), .FREQ(FREQ), .enable(enable), .CS(CS),
      .red(red), .green(green), .blue(blue), .clear(clear), .valid(valid), .busy(busy)
   );

   color_scan #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(WS)) dut_sat (
      .clk(clk), .reset(reset), .FREQ(FREQ), .enable(enable), .CS(CS_s),
      .red(red_s), .green(green_s), .blue(blue_s), .clear(clear_s), .valid(valid_s), .busy(busy_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // FREQ source; each new rise is logged with the posedge index that first samples it high.
   always @(negedge clk) begin
      logic nv;
      nv = 1'b0;
      if (gen_mode == 1) begin
         ph = ph + 1;
         if (ph >= period[CS]) ph = 0;
         nv = (ph < period[CS] / 2);
      end else if (gen_mode == 2) begin
         foreach (man_rise[i])
            if (cyc + 1 == man_rise[i] || cyc == man_rise[i]) nv = 1'b1;
      end
      if (nv && !FREQ) rises.push_back(cyc + 1);
      FREQ = nv;
   end

   // A rise sampled at posedge P is detected two edges later; it counts iff that lands in gate cycles 2..G.
   function automatic int model_count(input longint g0, input int maxv);
      int n;
      n = 0;
      foreach (rises[i])
         if (rises[i] >= g0 && rises[i] <= g0 + G - 2) n++;
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic goto(input longint n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic start_scan(output longint e0);
      @(negedge clk);
      enable = 1'b1;
      e0 = cyc + 1;
   endtask

   task automatic stop_scan();
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || CS !== 2'b00) begin
         errors++;
         $display("FAIL stop_idle: busy=%b CS=%b, expected busy=0 CS=00", busy, CS);
      end
   endtask

   task automatic check_scan(input longint e0);
      bit     stray;
      longint g0;
      stray = 1'b0;
      for (longint n = e0 + 1; n <= e0 + L; n++) begin
         goto(n);
         for (int k = 0; k < 4; k++) begin
            if (n == e0 + S + k * (S + G + 1) + G / 2) begin
               checks++;
               if (CS !== cs_of[k] || CS_s !== cs_of[k] || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL cs_seq ch%0d: CS=%b busy=%b, expected CS=%b busy=1", k, CS, busy, cs_of[k]);
               end
            end
         end
         if (n < e0 + L && (valid !== 1'b0 || valid_s !== 1'b0)) stray = 1'b1;
         if (n == e0 + L - 1) begin
            for (int k = 0; k < 4; k++) begin
               checks++;
               if (out8[k] !== exp8[k] || outs[k] !== exps[k]) begin
                  errors++;
                  $display("FAIL hold_before_valid ch%0d: got %0d/%0d, expected %0d/%0d", k, out8[k], outs[k], exp8[k], exps[k]);
               end
            end
         end
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL valid_latency: valid seen before cycle %0d, expected none", L);
      end
      checks++;
      if (valid !== 1'b1 || valid_s !== 1'b1) begin
         errors++;
         $display("FAIL valid_pulse: valid=%b valid_s=%b at cycle %0d, expected 1", valid, valid_s, L);
      end
      for (int k = 0; k < 4; k++) begin
         g0 = e0 + S + k * (S + G + 1);
         exp8[k] = W'(model_count(g0, (1 << W) - 1));
         exps[k] = WS'(model_count(g0, (1 << WS) - 1));
         checks++;
         if (out8[k] !== exp8[k] || outs[k] !== exps[k]) begin
            errors++;
            $display("FAIL count ch%0d: got %0d (sat %0d), expected %0d (sat %0d)", k, out8[k], outs[k], exp8[k], exps[k]);
         end
      end
      goto(e0 + L + 1);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_width: valid=%b one cycle after pulse, expected 0", valid);
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (CS !== 2'b00 || valid !== 1'b0 || busy !== 1'b0 || red !== 0 || green !== 0 || blue !== 0 || clear !== 0) begin
         errors++;
         $display("FAIL reset_state: CS=%b valid=%b busy=%b r/g/b/c=%0d/%0d/%0d/%0d, expected all 0", CS, valid, busy, red, green, blue, clear);
      end
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || CS !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: busy=%b valid=%b CS=%b, expected 0/0/00", busy, valid, CS);
      end
   endtask

   task automatic test_const();
      longint e0;
      for (int k = 0; k < 4; k++) period[k] = 10;
      rises.delete();
      gen_mode = 1;
      start_scan(e0);
      check_scan(e0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out8[k] < 9 || out8[k] > 11) begin
            errors++;
            $display("FAIL const_count ch%0d: got %0d, expected 10 +/-1", k, out8[k]);
         end
      end
      check_scan(e0 + L);
      stop_scan();
   endtask

   task automatic test_keyed();
      longint e0;
      period[0] = 5;  period[3] = 10;  period[1] = 20;  period[2] = 4;
      rises.delete();
      gen_mode = 1;
      start_scan(e0);
      check_scan(e0);
      checks++;
      if (red < 19 || red > 21 || green < 9 || green > 11 || blue < 4 || blue > 6 || clear < 24 || clear > 26) begin
         errors++;
         $display("FAIL keyed_counts: got %0d/%0d/%0d/%0d, expected 20/10/5/25 +/-1", red, green, blue, clear);
      end
      stop_scan();
   endtask

   task automatic test_saturation();
      longint e0;
      for (int k = 0; k < 4; k++) period[k] = 4;
      rises.delete();
      gen_mode = 1;
      start_scan(e0);
      check_scan(e0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (outs[k] !== 4'd15) begin
            errors++;
            $display("FAIL sat_no_wrap ch%0d: got %0d, expected 15", k, outs[k]);
         end
      end
      stop_scan();
   endtask

   task automatic test_abort();
      longint e0, t;
      bit     stray;
      for (int k = 0; k < 4; k++) period[k] = $urandom_range(4, 30);
      rises.delete();
      gen_mode = 1;
      start_scan(e0);
      check_scan(e0);
      t = e0 + L + S + 2 * (S + G + 1) + 30;
      goto(t);
      checks++;
      if (CS !== 2'b01 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_blue: CS=%b busy=%b, expected 01/1", CS, busy);
      end
      enable = 1'b0;
      goto(t + 1);
      checks++;
      if (busy !== 1'b0 || CS !== 2'b00 || valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b CS=%b valid=%b, expected 0/00/0", busy, CS, valid);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out8[k] !== exp8[k] || outs[k] !== exps[k]) begin
            errors++;
            $display("FAIL abort_hold ch%0d: got %0d/%0d, expected %0d/%0d", k, out8[k], outs[k], exp8[k], exps[k]);
         end
      end
      stray = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL abort_quiet: valid or busy seen while idle, expected none");
      end
      start_scan(e0);
      check_scan(e0);
      stop_scan();
   endtask

   task automatic test_last_edge();
      longint e0, g0, gg;
      gen_mode = 0;
      repeat (5) @(negedge clk);
      @(negedge clk);
      e0 = cyc + 1;
      g0 = e0 + S;
      gg = g0 + (S + G + 1);
      man_rise.delete();
      man_rise.push_back(g0 - 1);
      man_rise.push_back(g0 + 40);
      man_rise.push_back(g0 + G - 2);
      man_rise.push_back(gg + G - 1);
      rises.delete();
      gen_mode = 2;
      enable = 1'b1;
      check_scan(e0);
      checks++;
      if (red !== 8'd2) begin
         errors++;
         $display("FAIL edge_window_red: got %0d, expected 2 (last-cycle counted, first-cycle cleared)", red);
      end
      checks++;
      if (green !== 8'd0) begin
         errors++;
         $display("FAIL late_edge_green: got %0d, expected 0", green);
      end
      stop_scan();
      gen_mode = 0;
   endtask

   task automatic test_random();
      longint e0;
      rises.delete();
      gen_mode = 1;
      start_scan(e0);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) period[k] = $urandom_range(4, 40);
         ph = $urandom_range(0, 3);
         check_scan(e0 + r * L);
      end
      stop_scan();
   endtask

   task automatic test_reset_async();
      longint e0;
      start_scan(e0);
      goto(e0 + 200);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (CS !== 2'b00 || valid !== 1'b0 || busy !== 1'b0 || red !== 0 || green !== 0 || blue !== 0 || clear !== 0 ||
          busy_s !== 1'b0 || red_s !== 0 || clear_s !== 0) begin
         errors++;
         $display("FAIL async_reset: CS=%b valid=%b busy=%b r/g/b/c=%0d/%0d/%0d/%0d, expected all 0", CS, valid, busy, red, green, blue, clear);
      end
      for (int k = 0; k < 4; k++) begin
         exp8[k] = '0;
         exps[k] = '0;
      end
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || CS !== 2'b00 || red !== 0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b valid=%b CS=%b red=%0d, expected 0/0/00/0", busy, valid, CS, red);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cs_of = '{2'b00, 2'b11, 2'b01, 2'b10};
      for (int k = 0; k < 4; k++) begin
         exp8[k]   = '0;
         exps[k]   = '0;
         period[k] = 10;
      end
      test_reset();
      test_const();
      test_keyed();
      test_saturation();
      test_abort();
      test_last_edge();
      test_random();
      test_reset_async();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/color_scan.md
Name: color_scan

Overview:
Sequencer and frequency meter for the TCS3200-style colour sensor. It drives the filter-select lines, waits for the sensor output to settle, and counts rising edges of the sensor's FREQ output over a fixed gate window. It does this for red, green, blue and clear in turn. It sits directly upstream of the divider stages that normalise each of red, green and blue by clear. It publishes all four counts together with a one-cycle valid strobe.

Parameters:
GATE_CYCLES, 1000000, clk cycles per counting window (10 ms at 100 MHz)
SETTLE_CYCLES, 10000, clk cycles of dead time after each filter change (100 us)
CNT_W, 16, width of each per-channel edge count (saturating)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
FREQ  in  1  sensor frequency output, asynchronous to clk
enable  in  1  level; high = scan continuously, low = stop
CS  out  2  filter select {S2,S3}: red=00, blue=01, clear=10, green=11
red  out  CNT_W  latest red count
green  out  CNT_W  latest green count
blue  out  CNT_W  latest blue count
clear  out  CNT_W  latest clear count
valid  out  1  one-cycle pulse when all four outputs update together
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, CS=00, red/green/blue/clear=0, valid=0, busy=0, all counters and shadow registers cleared.
- FREQ input path: 2-FF synchroniser, then rising-edge detect. An edge is counted on the cycle the detector fires. Reliable only for FREQ below clk/4; faster inputs are out of spec.
- Channel order: red -> green -> blue -> clear. CS is driven from the current channel register. CS changes only on entry to SETTLE.
- FSM:
  - IDLE: CS=00. When enable=1, go to SETTLE with channel=red.
  - SETTLE: runs exactly SETTLE_CYCLES cycles, counting 0..SETTLE_CYCLES-1. Edges are ignored. Then go to GATE.
  - GATE: runs exactly GATE_CYCLES cycles. The edge counter is cleared on the first GATE cycle, including an edge detected on that cycle. An edge detected on the last GATE cycle is counted. Then go to STORE.
  - STORE: 1 cycle. The count is written to the channel's shadow register.
    - For red, green or blue: channel advances to the next colour and the FSM goes to SETTLE.
    - For clear: all four shadows load into the outputs, visible after the next edge. valid=1 for exactly that one cycle. Then go to SETTLE(red) if enable=1, else IDLE.
- Count arithmetic: unsigned, CNT_W bits, saturates at all-ones. No wrap.
- Latency: one full scan is 4*(SETTLE_CYCLES+GATE_CYCLES+1) cycles from IDLE exit to valid.
- Synchroniser delay: edges arriving in the last 2-3 cycles of a window are dropped, not carried over. This is accepted.
- enable deasserted in SETTLE, GATE or STORE (other than clear-STORE): abort to IDLE on the next edge. Shadows are discarded, outputs hold their previous values, and no valid is produced.
- enable deasserted during clear-STORE: the publish and valid still happen, then go to IDLE.
- enable reasserted: always restarts at red with fresh counts.
- Outputs are stable between valid pulses. They are never partially updated.

Decomposition:
- Shared package color_pkg:
  - filter code constants CS_RED=2'b00, CS_BLUE=2'b01, CS_CLEAR=2'b10, CS_GREEN=2'b11
  - channel index enum (RED, GREEN, BLUE, CLEAR)
  - FSM state enum (IDLE, SETTLE, GATE, STORE)
- One sub-module: edge_sync, the 2-FF synchroniser plus rising-edge detector. It has ports clk, reset, d_async and rise_pulse, and it is reused for other asynchronous sensor inputs.

Test Plan:
(Bench parameters: GATE_CYCLES=100, SETTLE_CYCLES=10, CNT_W=8.)
1. Reset: assert reset low mid-simulation -> outputs immediately 0, CS=00, valid=0, busy=0. Release with enable=0 -> stays IDLE.
2. Constant FREQ period 10 clk, enable=1 -> valid pulses at cycle 444 after enable, then every 444 cycles. All four counts = 10 (+/-1). CS sequence is 00, 11, 01, 10.
3. FREQ period keyed off CS (red=5, green=10, blue=20, clear=4 clk) -> red=20, green=10, blue=5, clear=25 (+/-1), all updated on the same valid cycle.
4. Saturation: rerun with CNT_W=4 and FREQ period 4 -> every count=15, with no wrap to a small value.
5. Abort: after one good scan, drop enable in blue GATE -> IDLE next cycle, busy=0, CS=00, no valid, outputs hold the previous scan. Reassert enable -> restarts at red, next valid 444 cycles later.
6. Last-cycle edge: align a FREQ edge so the detector fires on the final GATE cycle of red -> counted. A detector pulse on the first GATE cycle -> not counted.
